// File: rtl/serv_mdu_pkg.sv
// -----------------------------------------------------------------------------
// serv_mdu_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - operation encodings (RV32M funct3)
//   - one-hot FSM state encoding
//   - iteration count and datapath width
//   - operand signedness helpers
// -----------------------------------------------------------------------------
package serv_mdu_pkg;

  localparam int XLEN      = 32;
  localparam int MDU_STEPS = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_RUN      = 5'b00010,
    S_FIX      = 5'b00100,
    S_DONE     = 5'b01000,
    S_WAIT_LOW = 5'b10000
  } mdu_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input mdu_op_e op);
    case (op)
      MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: rs1_signed = 1'b1;
      default:                                rs1_signed = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic rs2_signed(input mdu_op_e op);
    case (op)
      MDU_MULH, MDU_DIV, MDU_REM: rs2_signed = 1'b1;
      default:                    rs2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serv_mdu_iter_if.sv
// -----------------------------------------------------------------------------
// serv_mdu_iter_if
// Request/response bundle between the core extension port and the MDU.
//   mdu_valid  request, held until mdu_ready
//   mdu_op     RV32M funct3
//   mdu_rs1    operand a (multiplicand / dividend)
//   mdu_rs2    operand b (multiplier / divisor)
//   mdu_rd     result, valid while mdu_ready is high
//   mdu_ready  single-cycle completion pulse
// master = core side, slave = MDU side.
// -----------------------------------------------------------------------------
interface serv_mdu_iter_if;
  import serv_mdu_pkg::*;

  logic            mdu_valid;
  logic [2:0]      mdu_op;
  logic [XLEN-1:0] mdu_rs1;
  logic [XLEN-1:0] mdu_rs2;
  logic [XLEN-1:0] mdu_rd;
  logic            mdu_ready;

  modport master (
    output mdu_valid, mdu_op, mdu_rs1, mdu_rs2,
    input  mdu_rd, mdu_ready
  );

  modport slave (
    input  mdu_valid, mdu_op, mdu_rs1, mdu_rs2,
    output mdu_rd, mdu_ready
  );

endinterface

// File: rtl/serv_mdu_negate.sv
// -----------------------------------------------------------------------------
// serv_mdu_negate
// Conditional two's complement of a W-bit value.
//   i_neg  1  negate when high, pass through when low
//   i_val  W  input value
//   o_val  W  result
// -----------------------------------------------------------------------------
module serv_mdu_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/serv_mdu_iter.sv
// -----------------------------------------------------------------------------
// serv_mdu_iter
// Iterative RV32M multiply/divide unit, one partial step per cycle:
// shift-add multiply and restoring division on sign-stripped operands, with a
// final sign fixup. Fixed latency: request accepted in IDLE at cycle 0, ready
// pulse with result in cycle 34.
//   clk     in   clock, rising edge
//   i_rst   in   synchronous active-high reset
//   io_mdu  slave modport of serv_mdu_iter_if (valid/op/rs1/rs2 in,
//           rd/ready out)
// RESET_STRATEGY: "MINI" resets FSM, counter, ready and rd; "NONE" nothing.
// -----------------------------------------------------------------------------
module serv_mdu_iter
  import serv_mdu_pkg::*;
#(
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic           clk,
  input  logic           i_rst,
  serv_mdu_iter_if.slave io_mdu
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [4:0]  r_cnt;
  mdu_op_e     r_op;
  logic [31:0] r_abs_a;
  logic [31:0] r_abs_b;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_bzero;
  logic [63:0] r_acc;
  logic [31:0] r_rd;
  logic        r_ready;

  logic        w_rst;
  logic        w_load;
  logic        w_step;
  logic        w_fix;
  logic        w_last;
  mdu_op_e     w_in_op;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_add_a;
  logic [32:0] w_add_b;
  logic        w_add_cin;
  logic [33:0] w_add_sum;
  logic [63:0] w_acc_step;
  logic        w_fix_neg;
  logic [63:0] w_fix_in;
  logic [63:0] w_fix_out;
  logic [31:0] w_result;

  assign w_rst    = i_rst & RST_EN;
  assign w_last   = (r_cnt == 5'(MDU_STEPS - 1));
  assign w_in_op  = mdu_op_e'(io_mdu.mdu_op);
  assign w_sign_a = rs1_signed(w_in_op) & io_mdu.mdu_rs1[31];
  assign w_sign_b = rs2_signed(w_in_op) & io_mdu.mdu_rs2[31];

  serv_mdu_negate #(.W(32)) u_abs_a (
    .i_neg (w_sign_a),
    .i_val (io_mdu.mdu_rs1),
    .o_val (w_abs_a)
  );

  serv_mdu_negate #(.W(32)) u_abs_b (
    .i_neg (w_sign_b),
    .i_val (io_mdu.mdu_rs2),
    .o_val (w_abs_b)
  );

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt <= 5'd0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 5'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = io_mdu.mdu_valid ? S_RUN : S_IDLE;
      S_RUN:      w_state_nxt = w_last ? S_FIX : S_RUN;
      S_FIX:      w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_WAIT_LOW;
      // Holding here until valid drops keeps a late-released valid from
      // launching a second operation.
      S_WAIT_LOW: w_state_nxt = io_mdu.mdu_valid ? S_WAIT_LOW : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-decoded datapath controls
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = io_mdu.mdu_valid;
      S_RUN:   w_step = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: w_load = 1'b0;
    endcase
  end

  // Shared 33-bit adder operand selection: hi + |a| for multiply,
  // shifted remainder - |b| (as + ~b + 1) for divide
  always_comb begin
    w_add_a   = 33'd0;
    w_add_b   = 33'd0;
    w_add_cin = 1'b0;
    if (r_op[2]) begin
      w_add_a   = r_acc[63:31];
      w_add_b   = ~{1'b0, r_abs_b};
      w_add_cin = 1'b1;
    end else begin
      w_add_a   = {1'b0, r_acc[63:32]};
      w_add_b   = {1'b0, r_abs_a};
      w_add_cin = 1'b0;
    end
  end

  assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {33'd0, w_add_cin};

  // One multiply or divide step on the shared {hi,lo} / {rem,quo} register.
  // In divide, sum[33] is the no-borrow flag, i.e. shifted rem >= |b|.
  always_comb begin
    w_acc_step = r_acc;
    if (r_op[2]) begin
      if (w_add_sum[33]) begin
        w_acc_step = {w_add_sum[31:0], r_acc[30:0], 1'b1};
      end else begin
        w_acc_step = {r_acc[62:0], 1'b0};
      end
    end else begin
      if (r_acc[0]) begin
        w_acc_step = {w_add_sum[32:0], r_acc[31:1]};
      end else begin
        w_acc_step = {1'b0, r_acc[63:1]};
      end
    end
  end

  // Operand latch on acceptance, iteration otherwise
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_op     <= w_in_op;
      r_abs_a  <= w_abs_a;
      r_abs_b  <= w_abs_b;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_bzero  <= (io_mdu.mdu_rs2 == 32'd0);
      r_acc    <= w_in_op[2] ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
    end else if (w_step) begin
      r_acc    <= w_acc_step;
    end else begin
      r_acc    <= r_acc;
    end
  end

  // Result sign: a zero divisor keeps the all-ones quotient unnegated
  always_comb begin
    w_fix_neg = 1'b0;
    case (r_op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_neg = r_sign_a ^ r_sign_b;
      MDU_DIV, MDU_DIVU: w_fix_neg = (r_sign_a ^ r_sign_b) & ~r_bzero;
      MDU_REM, MDU_REMU: w_fix_neg = r_sign_a;
      default:           w_fix_neg = 1'b0;
    endcase
  end

  // Value to fix up: full product, or the zero-extended remainder/quotient
  always_comb begin
    w_fix_in = r_acc;
    if (!r_op[2]) begin
      w_fix_in = r_acc;
    end else if (r_op[1]) begin
      w_fix_in = {32'd0, r_acc[63:32]};
    end else begin
      w_fix_in = {32'd0, r_acc[31:0]};
    end
  end

  serv_mdu_negate #(.W(64)) u_fix (
    .i_neg (w_fix_neg),
    .i_val (w_fix_in),
    .o_val (w_fix_out)
  );

  // Output word select
  always_comb begin
    w_result = w_fix_out[31:0];
    if (r_op == MDU_MUL) begin
      w_result = w_fix_out[31:0];
    end else if (!r_op[2]) begin
      w_result = w_fix_out[63:32];
    end else begin
      w_result = w_fix_out[31:0];
    end
  end

  // Registered outputs: result captured in FIX, ready pulses in DONE
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_ready <= 1'b0;
      r_rd    <= 32'd0;
    end else begin
      r_ready <= w_fix;
      if (w_fix) begin
        r_rd <= w_result;
      end else begin
        r_rd <= r_rd;
      end
    end
  end

  assign io_mdu.mdu_rd    = r_rd;
  assign io_mdu.mdu_ready = r_ready;

endmodule

// File: tb/tb_serv_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_serv_mdu_iter
// Directed self-checking bench for serv_mdu_iter: reset state, every RV32M op,
// divide-by-zero and signed overflow, latency, single-cycle ready, valid held
// past ready, valid dropped mid-operation, and reset during RUN.
// -----------------------------------------------------------------------------
module tb_serv_mdu_iter;
  import serv_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serv_mdu_iter_if u_if ();

  serv_mdu_iter #(.RESET_STRATEGY("MINI")) u_dut (
    .clk    (clk),
    .i_rst  (rst),
    .io_mdu (u_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.mdu_valid = 1'b1;
    u_if.mdu_op    = op;
    u_if.mdu_rs1   = a;
    u_if.mdu_rs2   = b;
  endtask

  // Counts edges from the acceptance edge (=1) until ready is seen; after
  // acceptance the operands are scrambled and optionally valid is dropped.
  task automatic wait_ready(input bit drop, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        u_if.mdu_rs1 = $urandom;
        u_if.mdu_rs2 = $urandom;
        u_if.mdu_op  = 3'($urandom_range(7, 0));
        if (drop) u_if.mdu_valid = 1'b0;
      end
    end while (u_if.mdu_ready !== 1'b1 && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit drop);
    int lat;
    issue(op, a, b);
    wait_ready(drop, lat);
    check({tag, "_rd"}, u_if.mdu_rd, exp);
    check({tag, "_lat"}, 32'(lat), 32'd34);
    u_if.mdu_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, u_if.mdu_ready}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int highs;

    rst            = 1'b1;
    u_if.mdu_valid = 1'b0;
    u_if.mdu_op    = 3'd0;
    u_if.mdu_rs1   = 32'd0;
    u_if.mdu_rs2   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, u_if.mdu_ready}, 32'd0);
    check("rst_rd", u_if.mdu_rd, 32'd0);
    check("rst_state", 32'(u_dut.r_state), 32'(S_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul_7x6",    3'd0, 32'd7,        32'd6,        32'd42,       1'b0);
    run_op("mulh_m1m1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("mulhu_m1m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("mul_m3x5",   3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0);
    run_op("mulh_m3x5",  3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0);
    run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
    run_op("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
    run_op("div_m5_0",   3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b0);
    run_op("rem_m5_0",   3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0);
    run_op("divu_5_0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    run_op("remu_5_0",   3'd7, 32'd5,        32'd0,        32'd5,        1'b0);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);

    // Valid dropped right after acceptance: operation still completes
    run_op("mulhu_drop", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);

    // Valid held three cycles past ready: no second pulse
    issue(3'd0, 32'd7, 32'd6);
    wait_ready(1'b0, lat);
    check("hold_rd", u_if.mdu_rd, 32'd42);
    check("hold_lat", 32'(lat), 32'd34);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_no_pulse", {31'd0, u_if.mdu_ready}, 32'd0);
    end
    // Drop valid for one cycle, then present a new request
    u_if.mdu_valid = 1'b0;
    u_if.mdu_op    = 3'd5;
    u_if.mdu_rs1   = 32'd100;
    u_if.mdu_rs2   = 32'd7;
    @(posedge clk);
    #1;
    u_if.mdu_valid = 1'b1;
    wait_ready(1'b0, lat);
    check("reissue_rd", u_if.mdu_rd, 32'd14);
    check("reissue_lat", 32'(lat), 32'd34);
    u_if.mdu_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reissue_pulse", {31'd0, u_if.mdu_ready}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in RUN cycle 10 with valid still high: reset wins
    issue(3'd0, 32'd7, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", 32'(u_dut.r_state), 32'(S_IDLE));
    check("midrst_ready", {31'd0, u_if.mdu_ready}, 32'd0);
    check("midrst_rd", u_if.mdu_rd, 32'd0);
    rst = 1'b0;
    u_if.mdu_valid = 1'b0;
    highs = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (u_if.mdu_ready === 1'b1) highs++;
    end
    check("midrst_no_ready", 32'(highs), 32'd0);
    run_op("post_rst_div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serv_mdu_iter.md
# serv_mdu_iter

Iterative RV32M multiply/divide unit that consumes the extension interface of the SERV register-file top (`o_ext_rs1`, `o_ext_rs2`, `o_ext_funct3`, `o_mdu_valid`) and returns the result through `i_ext_rd` and `i_ext_ready`. It computes one partial step per cycle:
- shift-add for MUL/MULH/MULHSU/MULHU;
- restoring division for DIV/DIVU/REM/REMU.

Operation is fixed-latency, with RISC-V-mandated results for divide-by-zero and signed overflow.

## Interface
- `RESET_STRATEGY`, default "MINI": "MINI" resets FSM, counter, `o_mdu_ready` and `o_mdu_rd`; "NONE" resets nothing.
- `clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_mdu_valid`  in  1  request; held high until `o_mdu_ready`.
- `i_mdu_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_mdu_rs1`  in  32  operand a (multiplicand / dividend).
- `i_mdu_rs2`  in  32  operand b (multiplier / divisor).
- `o_mdu_rd`  out  32  result; valid only while `o_mdu_ready`=1.
- `o_mdu_ready`  out  1  single-cycle completion pulse.

## Operation
- **FSM states:** IDLE, RUN, FIX, DONE, WAIT_LOW.
- **IDLE**
  - On `i_mdu_valid`=1, latch op, `|a|`, `|b|`, sign of a, sign of b, and divisor-zero flag; counter=0; go to RUN.
  - Signedness per op: rs1 is signed for ops 1, 2, 4, 6; rs2 is signed for ops 1, 4, 6.
- **RUN** (32 cycles, counter 0..31, wraps to FIX after 31)
  - Multiply: 64-bit accumulator `{hi, lo}`. If `lo[0]`, add `|a|` into hi with 33-bit carry; then shift right 1.
  - Divide: `{rem, quo}` shift left 1. If `rem ≥ |b|`, set `rem -= |b|` and `quo[0]=1`.
- **FIX** (1 cycle)
  - Result negative when:
    - mul: sign a XOR sign b;
    - quotient: sign a XOR sign b, and divisor nonzero;
    - remainder: sign a.
  - When negative, take the two's complement of the 64-bit product, quotient, or remainder.
  - Select output: MUL → `lo`; MULH* → `hi`; DIV* → quo; REM* → rem. Register into `o_mdu_rd`.
- **DONE:** `o_mdu_ready`=1 for exactly this cycle; go to WAIT_LOW.
- **WAIT_LOW:** stay until `i_mdu_valid`=0, then go to IDLE. This prevents double-issue when the core releases valid one cycle late.
- **Divide by zero:** quotient = 0xFFFFFFFF; remainder = rs1. The algorithm produces these naturally; quotient negation is suppressed by the zero flag.
- **Signed overflow** (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of 32-bit unsigned `|a|` = 2^31; no special case.
- **Valid deasserted mid-operation:** ignored. The operation completes, and ready still pulses. Operand or op changes after IDLE acceptance are ignored.

## Timing
- **Latency:** valid first seen in IDLE at cycle 0 → RUN cycles 1–32 → FIX cycle 33 → `o_mdu_ready`=1 and `o_mdu_rd` valid in cycle 34.
- **Throughput:** one op per 36 cycles minimum (DONE, then WAIT_LOW sees valid low, then IDLE).
- **Reset values** (MINI): state IDLE, counter 0, `o_mdu_ready`=0, `o_mdu_rd`=0.
- **Reset mid-operation:** `i_rst` high in any cycle forces IDLE at the next edge, with no ready pulse. This includes the DONE cycle: `o_mdu_ready` is 0 the cycle after reset.
- **Valid and reset in the same cycle:** reset wins; the request must be re-presented.
- `o_mdu_ready` is never high in two consecutive cycles.

## Structure
- Shared package / include `serv_mdu_pkg`:
  - op encodings (`MDU_MUL` … `MDU_REMU`);
  - FSM state encoding (one-hot, 5 bits);
  - `MDU_STEPS` = 32.
- Sub-module `serv_mdu_negate`: width-parameterised conditional two's complement (`i_neg`, `i_val`, `o_val`). Instantiated for operand abs (32) and result fixup (64).
- Datapath: one 64-bit shared shift register (product, or `{rem, quo}`), a 33-bit adder/subtractor, and a 5-bit counter.

## Test plan
- MUL 7 × 6, op 0 → `o_mdu_rd`=42, ready exactly at cycle 34 after valid, single-cycle pulse.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV −5 / 0 → 0xFFFFFFFF. REM −5 / 0 → 0xFFFFFFFB. DIV 0x80000000 / −1 → 0x80000000. REM same → 0.
- Valid held high 3 cycles past ready → no second ready pulse. Drop valid for 1 cycle, then reassert → new op completes 34 cycles after acceptance in IDLE.
- Assert `i_rst` at RUN cycle 10 → next cycle IDLE, no ready pulse. A new request is accepted normally with full 34-cycle latency.
